// File: rtl/rgb_pwm_pkg.sv
// Shared constants and state encoding for the RGB PWM fader.
package rgb_pwm_pkg;

    localparam int DUTY_W   = 8;
    localparam int NUM_CH   = 3;

    localparam int CH_RED   = 2;
    localparam int CH_GREEN = 1;
    localparam int CH_BLUE  = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        FADING = 1'b1
    } state_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel: current/target/shadow duty, fade stepping and compare.
// Optional gamma correction of the shadow duty with `define RGB_PWM_GAMMA_EN.
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_imm,
    input  logic              load_target,
    input  logic              step,
    input  logic              shadow_load,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic [DUTY_W-1:0] pwm_cnt,
    output logic [DUTY_W-1:0] current,
    output logic              done,
    output logic              pwm
);

    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] stepped;
    logic [DUTY_W-1:0] shadow_next;

    // NOTE: defaults are assigned first so no latch is inferred on any path.
    always_comb begin
        stepped = current;
        if (current < target)
            stepped = current + DUTY_W'(1);
        else if (current > target)
            stepped = current - DUTY_W'(1);
    end

    // Channel is finished once the value it is about to take equals the target.
    assign done = (stepped == target);

`ifdef RGB_PWM_GAMMA_EN
    logic [2*DUTY_W-1:0] square;
    assign square      = {{DUTY_W{1'b0}}, current} * {{DUTY_W{1'b0}}, current};
    assign shadow_next = square[2*DUTY_W-1:DUTY_W];
`else
    assign shadow_next = current;
`endif

    // NOTE: non-blocking assignments let the shadow sample the pre-step current on a shared wrap edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            current <= '0;
            target  <= '0;
            shadow  <= '0;
            pwm     <= 1'b0;
        end else begin
            if (load_imm) begin
                current <= cmd_duty;
                target  <= cmd_duty;
            end else if (load_target) begin
                target  <= cmd_duty;
            end else if (step) begin
                current <= stepped;
            end
            if (shadow_load)
                shadow <= shadow_next;
            pwm <= (pwm_cnt < shadow);
        end
    end

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB PWM generator with jump/fade colour commands for the iCE40 RGB driver.
// Define RGB_PWM_GAMMA_EN to square-law correct the duty seen by the compare.
module rgb_pwm_fader
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE     = 188,
    parameter int FADE_PERIODS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [NUM_CH*DUTY_W-1:0] cmd_rgb,
    input  logic                     cmd_imm,
    output logic                     busy,
    output logic                     period_start,
    output logic                     pwm_red,
    output logic                     pwm_green,
    output logic                     pwm_blue
);

    localparam int PRE_W  = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
    localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

    logic [PRE_W-1:0]         pre_cnt;
    logic [DUTY_W-1:0]        pwm_cnt;
    logic [FADE_W-1:0]        fade_cnt;
    state_t                   state, state_next;
    logic                     tick, wrap, accept, fade_last, step;
    logic [NUM_CH-1:0]        pwm_bits;
    logic [NUM_CH-1:0]        ch_done;
    logic [NUM_CH*DUTY_W-1:0] cur_rgb;

    assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign wrap      = tick && (pwm_cnt == '1);
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state == FADING);
    assign accept    = cmd_valid && cmd_ready;
    assign fade_last = (fade_cnt == FADE_W'(FADE_PERIODS - 1));
    assign step      = busy && wrap && fade_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            fade_cnt     <= '0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + PRE_W'(1);
            period_start <= wrap;
            if (tick)
                pwm_cnt <= pwm_cnt + DUTY_W'(1);
            if (accept && !cmd_imm)
                fade_cnt <= '0;
            else if (busy && wrap)
                fade_cnt <= fade_last ? '0 : fade_cnt + FADE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (accept && !cmd_imm && (cmd_rgb != cur_rgb))
                    state_next = FADING;
            FADING:
                if (step && (&ch_done))
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rgb_pwm_channel u_channel (
            .clk         (clk),
            .rst         (rst),
            .load_imm    (accept && cmd_imm),
            .load_target (accept && !cmd_imm),
            .step        (step),
            .shadow_load (wrap),
            .cmd_duty    (cmd_rgb[c*DUTY_W +: DUTY_W]),
            .pwm_cnt     (pwm_cnt),
            .current     (cur_rgb[c*DUTY_W +: DUTY_W]),
            .done        (ch_done[c]),
            .pwm         (pwm_bits[c])
        );
    end

    assign pwm_red   = pwm_bits[CH_RED];
    assign pwm_green = pwm_bits[CH_GREEN];
    assign pwm_blue  = pwm_bits[CH_BLUE];

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Scoreboard bench for rgb_pwm_fader with PRESCALE=1, FADE_PERIODS=2.
// Per-period high counts are compared against expectations queued at stimulus time.
module tb_rgb_pwm_fader;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_rgb;
    logic        cmd_imm;
    logic        busy;
    logic        period_start;
    logic        pwm_red;
    logic        pwm_green;
    logic        pwm_blue;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rgb_pwm_fader #(
        .PRESCALE     (1),
        .FADE_PERIODS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rgb      (cmd_rgb),
        .cmd_imm      (cmd_imm),
        .busy         (busy),
        .period_start (period_start),
        .pwm_red      (pwm_red),
        .pwm_green    (pwm_green),
        .pwm_blue     (pwm_blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int shade(input int c);
`ifdef RGB_PWM_GAMMA_EN
        return (c * c) >> 8;
`else
        return c;
`endif
    endfunction

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %0d with no expectation queued", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                n_err++;
                $error("FAIL %s/%s: observed %0d expected %0d", e.tag, tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_period(input bit b, input int r, input int g, input int bl);
        push("busy", int'(b));
        push("cmd_ready", int'(!b));
        push("red_high", r);
        push("green_high", g);
        push("blue_high", bl);
    endtask

    // Waits for the next period_start strobe, then counts highs over one full period.
    task automatic measure();
        int   n;
        int   r, g, b;
        logic got;
        n = 0;
        while (period_start !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        got = (period_start === 1'b1);
        n_cmp++;
        assert (got === 1'b1)
        else begin
            n_err++;
            $error("FAIL period_start_wait: observed %0b expected 1", got);
        end
        check("busy", {31'd0, busy});
        check("cmd_ready", {31'd0, cmd_ready});
        r = 0;
        g = 0;
        b = 0;
        repeat (256) begin
            @(negedge clk);
            r += int'(pwm_red);
            g += int'(pwm_green);
            b += int'(pwm_blue);
        end
        check("red_high", r);
        check("green_high", g);
        check("blue_high", b);
    endtask

    task automatic check_pins(input bit r, input bit g, input bit b);
        push("pwm_red", int'(r));
        push("pwm_green", int'(g));
        push("pwm_blue", int'(b));
        check("pwm_red", {31'd0, pwm_red});
        check("pwm_green", {31'd0, pwm_green});
        check("pwm_blue", {31'd0, pwm_blue});
    endtask

    task automatic send(input logic [23:0] rgb, input logic imm);
        cmd_rgb   = rgb;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_rgb   = '0;
        cmd_imm   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_pins(1'b0, 1'b0, 1'b0);
        push("busy_rst", 0);
        check("busy_rst", {31'd0, busy});
        push("ready_in_rst", 0);
        check("ready_in_rst", {31'd0, cmd_ready});
        push("period_start_rst", 0);
        check("period_start_rst", {31'd0, period_start});
        rst = 1'b0;
        #1;
        push("ready_after_rst", 1);
        check("ready_after_rst", {31'd0, cmd_ready});

        // Immediate load
        @(negedge clk);
        send(24'h4080FF, 1'b1);
        expect_period(1'b0, 64, 128, 255);
        measure();

        // Clear, then fade red 0 -> 3 while a competing command is held on the bus
        send(24'h000000, 1'b1);
        send(24'h030000, 1'b0);
        push("busy_fade", 1);
        check("busy_fade", {31'd0, busy});
        push("ready_fade", 0);
        check("ready_fade", {31'd0, cmd_ready});
        cmd_rgb   = 24'h00FF00;
        cmd_imm   = 1'b1;
        cmd_valid = 1'b1;
        repeat (10) @(negedge clk);
        cmd_valid = 1'b0;
        cmd_imm   = 1'b0;
        expect_period(1'b1, 0, 0, 0);
        expect_period(1'b1, 0, 0, 0);
        expect_period(1'b1, 1, 0, 0);
        expect_period(1'b1, 1, 0, 0);
        expect_period(1'b1, 2, 0, 0);
        expect_period(1'b0, 2, 0, 0);
        expect_period(1'b0, 3, 0, 0);
        repeat (7) measure();

        // Reset pulse in the middle of a fade towards 0x0A0A0A
        send(24'h0A0A0A, 1'b0);
        expect_period(1'b1, 3, 0, 0);
        expect_period(1'b1, 3, 0, 0);
        expect_period(1'b1, 4, 1, 1);
        repeat (3) measure();
        @(negedge clk);
        check_pins(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_pins(1'b0, 1'b0, 1'b0);
        push("busy_midfade_rst", 0);
        check("busy_midfade_rst", {31'd0, busy});
        push("ready_midfade_rst", 0);
        check("ready_midfade_rst", {31'd0, cmd_ready});
        rst = 1'b0;
        #1;
        push("ready_release", 1);
        check("ready_release", {31'd0, cmd_ready});
        expect_period(1'b0, 0, 0, 0);
        measure();

        // Duty extremes through the (optional) gamma path
        send(24'h80FF00, 1'b1);
        expect_period(1'b0, shade(8'h80), shade(8'hFF), shade(8'h00));
        measure();
        send(24'h01FE00, 1'b1);
        expect_period(1'b0, shade(8'h01), shade(8'hFE), shade(8'h00));
        measure();

        n_cmp++;
        assert (sb.size() == 0)
        else begin
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
